// File: rtl/sop5_sweep_checker.sv
// Exhaustive 32-vector sweep driver and checker for the 5-input SOP stage (S_OR2).
// Each vector is held for SETTLE cycles, then dut_s is sampled and compared with GOLDEN_MASK.
module sop5_sweep_checker #(
  parameter logic [31:0] GOLDEN_MASK = 32'h0A3E8C5C,
  parameter int unsigned SETTLE      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_s,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       K,
  output logic       M,
  output logic [4:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic       first_fail_valid,
  output logic [4:0] first_fail_idx
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [3:0] settle_cnt;
  logic [4:0] stim;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      settle_cnt       <= '0;
      stim             <= '0;
      vec_idx          <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state            <= ST_SETTLE;
            settle_cnt       <= '0;
            stim             <= '0;
            vec_idx          <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
            stim  <= '0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LAST) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state <= ST_IDLE;
            stim  <= '0;
          end else begin
            if (dut_s != GOLDEN_MASK[vec_idx]) begin
              err_count <= err_count + 6'd1;
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= vec_idx;
              end
            end
            // Stimulus advances together with vec_idx so X..M never lag the index;
            // on the last vector both stay at 31 for DONE.
            if (vec_idx == 5'd31) begin
              state <= ST_DONE;
            end else begin
              vec_idx    <= vec_idx + 5'd1;
              stim       <= vec_idx + 5'd1;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign {X, Y, Z, K, M} = stim;

  always_comb begin
    busy = (state == ST_SETTLE) || (state == ST_CHECK);
    done = (state == ST_DONE);
    pass = (state == ST_DONE) && (err_count == 6'd0);
  end

endmodule

// File: tb/tb_sop5_sweep_checker.sv
// Self-checking bench for sop5_sweep_checker: a behavioural SOP model with a
// fault-injection mask drives dut_s; results are predicted from the mask alone.
module tb_sop5_sweep_checker;

  localparam logic [31:0] GOLD = 32'h0A3E8C5C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic dut_s;
  logic X, Y, Z, K, M;
  logic [4:0] vec_idx, first_fail_idx;
  logic busy, done, pass, first_fail_valid;
  logic [5:0] err_count;

  logic start2 = 1'b0, abort2 = 1'b0;
  logic dut_s2;
  logic X2, Y2, Z2, K2, M2;
  logic [4:0] vec_idx2, first_fail_idx2;
  logic busy2, done2, pass2, first_fail_valid2;
  logic [5:0] err_count2;

  logic [31:0] flip = '0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Function under test: golden SOP table with selected vectors inverted.
  logic [4:0] cur_vec, cur_vec2;
  assign cur_vec  = {X, Y, Z, K, M};
  assign cur_vec2 = {X2, Y2, Z2, K2, M2};
  assign dut_s  = GOLD[cur_vec] ^ flip[cur_vec];
  assign dut_s2 = GOLD[cur_vec2];

  sop5_sweep_checker #(.GOLDEN_MASK(GOLD), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_s(dut_s),
    .X(X), .Y(Y), .Z(Z), .K(K), .M(M), .vec_idx(vec_idx), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx));

  sop5_sweep_checker #(.GOLDEN_MASK(GOLD), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .dut_s(dut_s2),
    .X(X2), .Y(Y2), .Z(Z2), .K(K2), .M(M2), .vec_idx(vec_idx2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err_count2),
    .first_fail_valid(first_fail_valid2), .first_fail_idx(first_fail_idx2));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int first1(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Per-cycle invariants while outputs are meaningful.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        chk("stim_eq_idx", int'(cur_vec), int'(vec_idx));
        chk("busy_not_done", int'(done), 0);
      end
      if (done) chk("done_stim31", int'(cur_vec), 31);
      if (busy2) chk("stim_eq_idx_s1", int'(cur_vec2), int'(vec_idx2));
    end
  end

  task automatic pulse_start(input logic with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; optional stray start at edge inj.
  task automatic wait_done(input int inj, output int n);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1 start = 1'b0;
      if (done) break;
      if (n == inj) start = 1'b1;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (int'(vec_idx) != idx && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    chk("reach_idx", int'(vec_idx), idx);
  endtask

  task automatic check_results(input int exp_err, input int exp_ffi);
    chk("done", int'(done), 1);
    chk("busy_done", int'(busy), 0);
    chk("err_count", int'(err_count), exp_err);
    chk("ff_valid", int'(first_fail_valid), int'(exp_err != 0));
    chk("ff_idx", int'(first_fail_idx), exp_ffi);
    chk("pass", int'(pass), int'(exp_err == 0));
    chk("vec_idx_end", int'(vec_idx), 31);
  endtask

  task automatic run_sweep(input logic [31:0] f, input int exp_err, input int exp_ffi, input int inj);
    int n;
    flip = f;
    pulse_start(1'b0);
    chk("busy_after_start", int'(busy), 1);
    wait_done(inj, n);
    chk("sweep_cycles", n, 96);
    check_results(exp_err, exp_ffi);
  endtask

  initial begin
    int n;
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_stim", int'(cur_vec), 0);
    chk("rst_idx", int'(vec_idx), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_ffv", int'(first_fail_valid), 0);
    chk("rst_ffi", int'(first_fail_idx), 0);
    rst_n = 1'b1;

    // Literal-pinned runs.
    run_sweep(32'h0, 0, 0, 0);
    run_sweep(GOLD, 14, 2, 0);
    run_sweep(~GOLD, 18, 0, 0);
    run_sweep(32'h0020_0000, 1, 21, 0);
    run_sweep(32'h4000_0080, 2, 7, 0);

    // Start in DONE clears results immediately and reruns identically.
    flip = GOLD;
    pulse_start(1'b0);
    chk("rerun_done_clr", int'(done), 0);
    chk("rerun_err_clr", int'(err_count), 0);
    chk("rerun_ffv_clr", int'(first_fail_valid), 0);
    wait_done(0, n);
    chk("rerun_cycles", n, 96);
    check_results(14, 2);

    // Stray start mid-sweep changes nothing.
    run_sweep(32'h0000_0800, 1, 11, 40);

    // Reset while vec_idx==10.
    flip = 32'h0;
    pulse_start(1'b0);
    wait_idx(10);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_stim", int'(cur_vec), 0);
    chk("mrst_idx", int'(vec_idx), 0);
    chk("mrst_err", int'(err_count), 0);
    run_sweep(32'h0, 0, 0, 0);

    // Abort (with simultaneous start) at vec 5 keeps partial results.
    flip = 32'h0000_0008;
    pulse_start(1'b0);
    wait_idx(5);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_stim", int'(cur_vec), 0);
    chk("abort_err", int'(err_count), 1);
    chk("abort_ffv", int'(first_fail_valid), 1);
    chk("abort_ffi", int'(first_fail_idx), 3);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("idle_abort_err", int'(err_count), 1);
    chk("idle_abort_busy", int'(busy), 0);
    // In IDLE, start beats abort.
    pulse_start(1'b1);
    chk("start_wins_busy", int'(busy), 1);
    chk("start_wins_err", int'(err_count), 0);
    wait_done(0, n);
    chk("after_abort_cycles", n, 96);
    check_results(1, 3);

    // Randomized fault masks checked against the model.
    for (int k = 0; k < 4; k++) begin
      r = $urandom;
      run_sweep(r, popc(r), first1(r), 0);
    end

    // SETTLE=1 instance: 2 cycles per vector.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (done2) break;
    end
    chk("s1_cycles", n, 64);
    chk("s1_done", int'(done2), 1);
    chk("s1_pass", int'(pass2), 1);
    chk("s1_err", int'(err_count2), 0);
    chk("s1_idx", int'(vec_idx2), 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
